// File: rtl/microcode_sequencer.sv
// Control sequencer: decodes RV32I ops into a registered 16-bit control word and expands the
// custom MULU and MEMCOPY instructions into multi-cycle micro-op sequences.
module microcode_sequencer #(
   parameter int unsigned OPCODE_LENGTH = 7,
   parameter int unsigned FUNCT3_LENGTH = 3,
   parameter int unsigned FUNCT7_LENGTH = 7,
   parameter int unsigned CTRL_WIDTH    = 16,
   parameter int unsigned MUL_LATENCY   = 4,
   parameter int unsigned CNT_WIDTH     = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   input  logic [OPCODE_LENGTH-1:0] Opcode,
   input  logic [FUNCT3_LENGTH-1:0] Funct3,
   input  logic [FUNCT7_LENGTH-1:0] Funct7,
   input  logic [CNT_WIDTH-1:0]     copy_len,
   output logic [CTRL_WIDTH-1:0]    ctrl_word,
   output logic                     ctrl_valid,
   output logic                     uop_last,
   output logic [CNT_WIDTH-1:0]     copy_index,
   output logic                     illegal
);

   localparam int unsigned MulW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluSll  = 4'd2;
   localparam logic [3:0] AluSlt  = 4'd3;
   localparam logic [3:0] AluSltu = 4'd4;
   localparam logic [3:0] AluXor  = 4'd5;
   localparam logic [3:0] AluSrl  = 4'd6;
   localparam logic [3:0] AluSra  = 4'd7;
   localparam logic [3:0] AluOr   = 4'd8;
   localparam logic [3:0] AluAnd  = 4'd9;
   localparam logic [3:0] AluMulu = 4'd11;

   localparam logic [15:0] MulMidWord  = 16'h0160;
   localparam logic [15:0] MulLastWord = 16'h8160;
   localparam logic [15:0] LwWord      = 16'hF003;
   localparam logic [15:0] SwWord      = 16'h4803;

   typedef enum logic [1:0] {StIdle, StMul, StCpyRd, StCpyWr} state_e;

   state_e              state_q, state_d;
   logic [MulW-1:0]     mul_cnt_q, mul_cnt_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;
   logic [CNT_WIDTH-1:0] idx_q, idx_d;
   logic [15:0]         ctrl_q, ctrl_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                illegal_q, illegal_d;

   logic [6:0]  op;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [3:0]  alu_f3;
   logic        f7_zero, f7_alt;
   logic [15:0] dec_word;
   logic        dec_illegal, is_mul, is_cpy, cpy_final;

   // Field order: regWrite immSel LoadMux MemRead MemWrite Jalr Branch ALU BranchSel LS
   function automatic logic [15:0] cw(input logic rw, input logic imm, input logic lm,
                                      input logic mr, input logic mw, input logic jr,
                                      input logic br, input logic [3:0] alu,
                                      input logic [1:0] bs, input logic [2:0] ls);
      return {rw, imm, lm, mr, mw, jr, br, alu, bs, ls};
   endfunction

   assign op      = 7'(Opcode);
   assign f3      = 3'(Funct3);
   assign f7      = 7'(Funct7);
   assign f7_zero = (f7 == 7'b0000000);
   assign f7_alt  = (f7 == 7'b0100000);

   always_comb begin
      alu_f3 = AluAdd;
      unique case (f3)
         3'b000: alu_f3 = AluAdd;
         3'b001: alu_f3 = AluSll;
         3'b010: alu_f3 = AluSlt;
         3'b011: alu_f3 = AluSltu;
         3'b100: alu_f3 = AluXor;
         3'b101: alu_f3 = AluSrl;
         3'b110: alu_f3 = AluOr;
         3'b111: alu_f3 = AluAnd;
         default: alu_f3 = AluAdd;
      endcase
   end

   always_comb begin
      dec_word    = 16'h0000;
      dec_illegal = 1'b0;
      is_mul      = 1'b0;
      is_cpy      = 1'b0;
      case (op)
         7'b0110011: begin
            if (f7_zero) dec_word = cw(1, 0, 0, 0, 0, 0, 0, alu_f3, 2'b00, 3'b000);
            else if (f7_alt && f3 == 3'b000) dec_word = cw(1, 0, 0, 0, 0, 0, 0, AluSub, 2'b00, 3'b000);
            else if (f7_alt && f3 == 3'b101) dec_word = cw(1, 0, 0, 0, 0, 0, 0, AluSra, 2'b00, 3'b000);
            else dec_illegal = 1'b1;
         end
         7'b0010011: begin
            if (f3 == 3'b001 && !f7_zero) dec_illegal = 1'b1;
            else if (f3 == 3'b101 && f7_alt) dec_word = cw(1, 1, 0, 0, 0, 0, 0, AluSra, 2'b00, 3'b000);
            else if (f3 == 3'b101 && !f7_zero) dec_illegal = 1'b1;
            else dec_word = cw(1, 1, 0, 0, 0, 0, 0, alu_f3, 2'b00, 3'b000);
         end
         7'b0000011: begin
            // LS encodes the access as funct3+1 so that 0 never means a memory op
            if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_illegal = 1'b1;
            else dec_word = cw(1, 1, 1, 1, 0, 0, 0, AluAdd, 2'b00, 3'(f3 + 3'd1));
         end
         7'b0100011: begin
            if (f3[2] || f3 == 3'b011) dec_illegal = 1'b1;
            else dec_word = cw(0, 1, 0, 0, 1, 0, 0, AluAdd, 2'b00, 3'(f3 + 3'd1));
         end
         7'b1100011: begin
            if (f3[2:1] == 2'b01) dec_illegal = 1'b1;
            else dec_word = cw(0, 0, 0, 0, 0, 0, 1,
                               f3[2] ? (f3[1] ? AluSltu : AluSlt) : AluSub,
                               {f3[2], f3[0]}, 3'b000);
         end
         7'b1100111: begin
            if (f3 == 3'b000) dec_word = cw(1, 1, 0, 0, 0, 1, 0, AluAdd, 2'b00, 3'b000);
            else dec_illegal = 1'b1;
         end
         7'b0111111: is_mul = 1'b1;
         7'b1111111: is_cpy = 1'b1;
         default:    dec_illegal = 1'b1;
      endcase
   end

   assign instr_ready = (state_q == StIdle);
   assign cpy_final   = (idx_q == CNT_WIDTH'(count_q - 1'b1));

   always_comb begin
      state_d   = state_q;
      mul_cnt_d = mul_cnt_q;
      count_d   = count_q;
      idx_d     = idx_q;
      ctrl_d    = 16'h0000;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      illegal_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            idx_d = '0;
            if (instr_valid) begin
               valid_d = 1'b1;
               if (is_mul) begin
                  state_d   = StMul;
                  mul_cnt_d = MulW'(MUL_LATENCY - 1);
                  ctrl_d    = (MUL_LATENCY == 1) ? MulLastWord : MulMidWord;
                  last_d    = (MUL_LATENCY == 1);
               end else if (is_cpy && copy_len != '0) begin
                  state_d = StCpyRd;
                  count_d = copy_len;
                  ctrl_d  = LwWord;
               end else begin
                  ctrl_d    = dec_word;
                  last_d    = 1'b1;
                  illegal_d = dec_illegal;
               end
            end
         end
         StMul: begin
            // mul_cnt_q counts control cycles still to emit after the current one
            if (mul_cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               mul_cnt_d = mul_cnt_q - 1'b1;
               valid_d   = 1'b1;
               last_d    = (mul_cnt_q == MulW'(1));
               ctrl_d    = last_d ? MulLastWord : MulMidWord;
            end
         end
         StCpyRd: begin
            state_d = StCpyWr;
            valid_d = 1'b1;
            ctrl_d  = SwWord;
            last_d  = cpy_final;
         end
         StCpyWr: begin
            if (cpy_final) begin
               state_d = StIdle;
               idx_d   = '0;
            end else begin
               state_d = StCpyRd;
               idx_d   = idx_q + 1'b1;
               valid_d = 1'b1;
               ctrl_d  = LwWord;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         mul_cnt_q <= '0;
         count_q   <= '0;
         idx_q     <= '0;
         ctrl_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mul_cnt_q <= mul_cnt_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         ctrl_q    <= ctrl_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         illegal_q <= illegal_d;
      end
   end

   assign ctrl_word  = CTRL_WIDTH'(ctrl_q);
   assign ctrl_valid = valid_q;
   assign uop_last   = last_q;
   assign copy_index = idx_q;
   assign illegal    = illegal_q;

endmodule
